weather_report_tx: RTL and testbench

WEATHER_REPORT_TX -- requirements
Module: weather_report_tx

---
 rtl/weather_pkg.sv | 30 +++
 rtl/weather_class_fifo.sv | 56 +++++
 rtl/weather_report_tx.sv | 129 ++++++++++++
 tb/tb_weather_report_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weather_pkg.sv
// Shared weather constants: class codes, ASCII mapping and the UART transmitter state encoding.
package weather_pkg;

    localparam logic [2:0] CLASS_CLEAR         = 3'd0;
    localparam logic [2:0] CLASS_RAIN_OVERCAST = 3'd1;
    localparam logic [2:0] CLASS_RAIN_PARTLY   = 3'd2;
    localparam logic [2:0] CLASS_PARTLY        = 3'd3;
    localparam logic [2:0] CLASS_OVERCAST      = 3'd4;
    localparam logic [2:0] CLASS_MAX           = CLASS_OVERCAST;

    localparam logic [7:0] ASCII_BASE = 8'h30;
    localparam int         FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic class_is_legal(input logic [2:0] code);
        return code <= CLASS_MAX;
    endfunction

    // Codes 0..4 become the printable digits '0'..'4'.
    function automatic logic [7:0] class_to_ascii(input logic [2:0] code);
        return ASCII_BASE + {5'b0, code};
    endfunction

endpackage

// File: rtl/weather_class_fifo.sv
// Single-clock FIFO for class codes; writes are refused when full even if a read happens that cycle.
module weather_class_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointers wrap on their own because DEPTH is a power of two.
    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/weather_report_tx.sv
// Queues weather class codes and sends each as an ASCII digit over an 8N1 UART line.
module weather_report_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  class_in,
    input  logic        class_valid,
    output logic        class_ready,
    output logic        tx,
    output logic        tx_busy,
    output logic        err_code,
    output logic [15:0] frames_sent
);

    import weather_pkg::*;

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [2:0]    fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          hs, push, pop;
    logic          err_code_q, err_code_d;

    tx_state_e     state_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic [15:0]   frames_q;

    assign class_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign hs          = class_valid && class_ready;
    assign push        = hs && class_is_legal(class_in) && !fifo_full;
    assign pop         = (state_q == IDLE) && !fifo_empty;

    weather_class_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (class_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        err_code_d = hs && !class_is_legal(class_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_code_q <= 1'b0;
        else     err_code_q <= err_code_d;
    end

    // tx follows the state one cycle late, so a pop at edge N+1 shows the start bit at N+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            frames_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= class_to_ascii(fifo_rdata);
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_q == '0) begin
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_RELOAD;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'(FRAME_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == '0) begin
                        baud_q   <= BAUD_RELOAD;
                        frames_q <= frames_q + 16'd1;
                        state_q  <= IDLE;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = (state_q != IDLE);
    assign err_code    = err_code_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_weather_report_tx.sv
// Directed bench for weather_report_tx at CLKS_PER_BIT=4: a line monitor decodes frames into a queue.
module tb_weather_report_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  class_in;
    logic        class_valid;
    logic        class_ready;
    logic        tx;
    logic        tx_busy;
    logic        err_code;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         start;
    } frame_t;

    frame_t rxq[$];

    weather_report_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .class_in    (class_in),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .err_code    (err_code),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: start bit seen at edge S, data bit k sampled at S+5+4k, stop at S+37.
    initial begin
        frame_t fr;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && tx === 1'b0) begin
                fr.start = cyc;
                for (int k = 0; k < 8; k++) begin
                    repeat ((k == 0) ? 5 : 4) @(posedge clk);
                    #1;
                    fr.b[k] = tx;
                end
                repeat (4) @(posedge clk);
                #1;
                fr.stop = tx;
                rxq.push_back(fr);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic get_frame(input int budget, output frame_t f, output bit ok);
        ok = 1'b0;
        f.b = '0; f.stop = 1'b0; f.start = 0;
        for (int i = 0; i < budget; i++) begin
            if (rxq.size() > 0) begin
                f  = rxq.pop_front();
                ok = 1'b1;
                break;
            end
            wait_cyc(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; class_valid = 1'b0; class_in = 3'd0;
        wait_cyc(2);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        checks++; if (err_code !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_code); end
        checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL reset_frames got %h exp 0000", frames_sent); end
        checks++; if (class_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", class_ready); end
        #2 rst = 1'b0;
        wait_cyc(2);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy); end
    endtask

    task automatic test_single_frame();
        frame_t f; bit ok; int n;
        class_in = 3'd3; class_valid = 1'b1;
        wait_cyc(1);
        class_valid = 1'b0; n = cyc;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL single_edgeN got tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy); end
        wait_cyc(1);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b1) begin errors++; $display("FAIL single_edgeN1 got tx=%b busy=%b exp tx=1 busy=1", tx, tx_busy); end
        wait_cyc(1);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_N2 got %b exp 0", tx); end
        get_frame(100, f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_frame_timeout got none exp frame"); end
        checks++; if (f.start !== n + 2) begin errors++; $display("FAIL single_start_cycle got %0d exp %0d", f.start, n + 2); end
        checks++; if (f.b !== 8'h33) begin errors++; $display("FAIL single_byte got %h exp 33", f.b); end
        checks++; if (f.stop !== 1'b1) begin errors++; $display("FAIL single_stop got %b exp 1", f.stop); end
        wait_cyc(4);
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames got %0d exp 1", frames_sent); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_idle_after got %b exp 0", tx_busy); end
    endtask

    task automatic test_illegal_code();
        bit line_high;
        class_in = 3'd6; class_valid = 1'b1;
        wait_cyc(1);
        class_valid = 1'b0;
        checks++; if (err_code !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse got %b exp 1", err_code); end
        wait_cyc(1);
        checks++; if (err_code !== 1'b0) begin errors++; $display("FAIL illegal_err_width got %b exp 0", err_code); end
        line_high = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) line_high = 1'b0;
            wait_cyc(1);
        end
        checks++; if (line_high !== 1'b1) begin errors++; $display("FAIL illegal_line_idle got %b exp 1", line_high); end
        checks++; if (rxq.size() != 0) begin errors++; $display("FAIL illegal_no_frame got %0d exp 0", rxq.size()); end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL illegal_frames got %0d exp 1", frames_sent); end
    endtask

    // Second push lands on the edge that pops the first entry while count is 1.
    task automatic test_push_pop();
        frame_t f0, f1; bit ok0, ok1;
        class_in = 3'd1; class_valid = 1'b1;
        wait_cyc(1);
        class_in = 3'd4;
        wait_cyc(1);
        class_valid = 1'b0;
        checks++; if (dut.u_fifo.count !== 4'd1) begin errors++; $display("FAIL pushpop_count got %0d exp 1", dut.u_fifo.count); end
        get_frame(100, f0, ok0);
        get_frame(100, f1, ok1);
        checks++; if (!ok0 || !ok1) begin errors++; $display("FAIL pushpop_timeout got %b%b exp 11", ok0, ok1); end
        checks++; if (f0.b !== 8'h31 || f1.b !== 8'h34) begin errors++; $display("FAIL pushpop_order got %h %h exp 31 34", f0.b, f1.b); end
        checks++; if (f1.start - f0.start !== 10 * CPB + 1) begin errors++; $display("FAIL pushpop_period got %0d exp %0d", f1.start - f0.start, 10 * CPB + 1); end
        wait_cyc(5);
    endtask

    task automatic test_fill();
        int codes[9] = '{0, 1, 2, 3, 4, 0, 1, 2, 3};
        frame_t f; bit ok; int prev;
        for (int i = 0; i < 9; i++) begin
            class_in = codes[i][2:0]; class_valid = 1'b1;
            wait_cyc(1);
            checks++; if (class_ready !== (i < 8)) begin errors++; $display("FAIL fill_ready_%0d got %b exp %b", i, class_ready, (i < 8)); end
        end
        class_in = 3'd4;
        wait_cyc(1);
        class_valid = 1'b0;
        checks++; if (dut.u_fifo.count !== 4'd8) begin errors++; $display("FAIL fill_full_hold got %0d exp 8", dut.u_fifo.count); end
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            get_frame(100, f, ok);
            checks++; if (!ok || f.b !== (8'h30 + 8'(codes[i])) || f.stop !== 1'b1) begin
                errors++; $display("FAIL fill_frame_%0d got ok=%b byte=%h stop=%b exp byte=%h stop=1", i, ok, f.b, f.stop, 8'h30 + 8'(codes[i]));
            end
            if (i > 0) begin
                checks++; if (f.start - prev !== 10 * CPB + 1) begin errors++; $display("FAIL fill_period_%0d got %0d exp %0d", i, f.start - prev, 10 * CPB + 1); end
            end
            prev = f.start;
        end
        wait_cyc(60);
        checks++; if (rxq.size() != 0) begin errors++; $display("FAIL fill_extra_frame got %0d exp 0", rxq.size()); end
        checks++; if (frames_sent !== 16'd12) begin errors++; $display("FAIL fill_frames got %0d exp 12", frames_sent); end
    endtask

    task automatic test_wrap();
        frame_t f; bit ok;
        force dut.frames_q = 16'hFFFF;
        wait_cyc(1);
        release dut.frames_q;
        wait_cyc(1);
        checks++; if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", frames_sent); end
        class_in = 3'd0; class_valid = 1'b1;
        wait_cyc(1);
        class_valid = 1'b0;
        get_frame(100, f, ok);
        checks++; if (!ok || f.b !== 8'h30) begin errors++; $display("FAIL wrap_frame got ok=%b byte=%h exp byte=30", ok, f.b); end
        wait_cyc(5);
        checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h exp 0000", frames_sent); end
    endtask

    task automatic test_reset_mid();
        frame_t f; bit ok; bit line_high;
        class_in = 3'd2; class_valid = 1'b1;
        wait_cyc(1);
        class_in = 3'd3;
        wait_cyc(1);
        class_in = 3'd1;
        wait_cyc(1);
        class_valid = 1'b0;
        // Now at edge N+2 (start bit); data bit 4 is on the line from N+22.
        wait_cyc(21);
        checks++; if (tx_busy !== 1'b1 || dut.state_q !== weather_pkg::DATA) begin errors++; $display("FAIL mid_in_data got busy=%b exp busy=1", tx_busy); end
        #2 rst = 1'b1; class_valid = 1'b1; class_in = 3'd2;
        #1;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_line got tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy); end
        checks++; if (class_ready !== 1'b1 || dut.u_fifo.count !== 4'd0) begin errors++; $display("FAIL mid_rst_fifo got ready=%b count=%0d exp ready=1 count=0", class_ready, dut.u_fifo.count); end
        wait_cyc(3);
        checks++; if (dut.u_fifo.count !== 4'd0) begin errors++; $display("FAIL mid_rst_ignore_valid got %0d exp 0", dut.u_fifo.count); end
        #2 rst = 1'b0; class_valid = 1'b0;
        wait_cyc(50);
        rxq.delete();
        line_high = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) line_high = 1'b0;
            wait_cyc(1);
        end
        checks++; if (line_high !== 1'b1 || rxq.size() != 0) begin errors++; $display("FAIL mid_no_frames got line=%b frames=%0d exp line=1 frames=0", line_high, rxq.size()); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL mid_frames_cleared got %0d exp 0", frames_sent); end
        class_in = 3'd4; class_valid = 1'b1;
        wait_cyc(1);
        class_valid = 1'b0;
        get_frame(100, f, ok);
        checks++; if (!ok || f.b !== 8'h34) begin errors++; $display("FAIL mid_new_push got ok=%b byte=%h exp byte=34", ok, f.b); end
        wait_cyc(5);
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL mid_new_count got %0d exp 1", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_illegal_code();
        test_push_pop();
        test_fill();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
